cpu_bus_rr_arbiter: RTL and testbench
=====================================

// Module: cpu_bus_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one CPU-side bus master port among PORTS requesters (fetch, load/store, DMA, debug).
//  Latches the winner's rw/address/wdata, holds o_bus_request until i_bus_ready, then routes ready/rdata back to the winner.
//  Sits between the requester ports and the system bus; replaces fixed-priority two-port muxing.
// PARAMETERS
//  PORTS    4    number of requesters, 2..8
//  TIMEOUT  255  watchdog limit in cycles (used only with CPU_BUS_ARB_TIMEOUT_EN), 1..65535
// PORTS
//  i_clock        in   1         clock
//  i_reset        in   1         synchronous, active-high reset
//  i_req          in   PORTS     per-port request, level held until ready
//  i_rw           in   PORTS     per-port 1=write, 0=read
//  i_address      in   32*PORTS  per-port address, port k at [32k+31:32k]
//  i_wdata        in   32*PORTS  per-port write data
//  o_ready        out  PORTS     per-port completion strobe
//  o_rdata        out  32*PORTS  per-port read data
//  o_grant        out  PORTS     one-hot current owner, 0 when idle
//  o_bus_request  out  1         bus request
//  o_bus_rw       out  1         bus rw (registered)
//  o_bus_address  out  32        bus address (registered)
//  o_bus_wdata    out  32        bus write data (registered)
//  i_bus_ready    in   1         bus transaction complete
//  i_bus_rdata    in   32        bus read data
//  o_error        out  PORTS     per-port timeout strobe (only with CPU_BUS_ARB_TIMEOUT_EN, else tied 0)
// BEHAVIOUR
//  Reset: state=IDLE, last=PORTS-1, o_bus_rw/address/wdata=0, o_grant=0, o_bus_request=0, o_ready=0, o_error=0, o_rdata=0.
//  States: IDLE -> BUSY on any i_req; BUSY -> IDLE on i_bus_ready; BUSY -> ABORT on timeout; ABORT -> IDLE after 1 cycle.
//  IDLE: winner = first set i_req searching from last+1, wrapping modulo PORTS.
//   On the same edge, register its rw/address/wdata, set o_grant one-hot, set last=winner.
//  BUSY: o_bus_request=1 (combinational from state); bus outputs stable for the entire transaction.
//  o_ready[k] = BUSY & o_grant[k] & i_req[k] & i_bus_ready (combinational).
//  o_rdata slice k = i_bus_rdata when BUSY & o_grant[k] & i_req[k] & ~o_bus_rw, else 32'h0 (no tristates).
//  Completion: the edge with i_bus_ready returns to IDLE and clears o_grant.
//   Minimum one IDLE cycle between transactions; next winner is registered on that IDLE edge.
//  Requester drops i_req mid-BUSY: bus transaction still runs to i_bus_ready; no o_ready to anyone; no early release.
//  Simultaneous requests: strict rotation. A port just served has lowest priority next round; no starvation.
//  Bound: a continuously requesting port waits at most PORTS-1 transactions.
//  i_bus_ready while IDLE: ignored.
//  i_reset during BUSY: next edge returns to IDLE, o_bus_request=0; the in-flight requester gets no o_ready.
// CONFIGURATION
//  CPU_BUS_ARB_TIMEOUT_EN defined:
//   16-bit counter cleared on IDLE->BUSY, incremented each BUSY cycle without i_bus_ready.
//   At count==TIMEOUT: enter ABORT and drop o_bus_request.
//   In ABORT: o_error[grant] pulses 1 cycle, o_ready stays 0, then IDLE.
//  Undefined: no counter or ABORT state; BUSY waits indefinitely; o_error=0.
// STRUCTURE
//  Shared package cpu_bus_pkg: state encodings (ARB_IDLE=2'd0, ARB_BUSY=2'd1, ARB_ABORT=2'd2) and BUS_AW/BUS_DW=32.
//  One sub-module: cpu_bus_rr_pick (combinational: req vector + last index -> winner index + valid).
//   Shared with the future interrupt arbiter.
// TESTING
//  1. Single read: i_req=4'b0010, addr1=0x1000; bus ready after 3 cycles with rdata=0xDEADBEEF.
//     -> o_bus_address=0x1000, o_rdata1=0xDEADBEEF, o_ready=4'b0010 exactly 1 cycle.
//  2. All four ports request continuously, bus ready each cycle.
//     -> grants in order 0,1,2,3,0; each followed by one IDLE cycle.
//  3. Port 2 writes wdata=0x55AA; port 0 requests mid-transaction.
//     -> o_bus_wdata holds 0x55AA until ready; port 0 is granted next.
//  4. Port 3 drops i_req before ready.
//     -> bus completes, o_ready=0, arbiter returns to IDLE.
//  5. i_reset asserted in BUSY.
//     -> next cycle o_bus_request=0, o_grant=0, all bus outputs 0.
//  6. (CPU_BUS_ARB_TIMEOUT_EN, TIMEOUT=8) bus never ready.
//     -> o_bus_request falls after 8 BUSY cycles; o_error[k] pulses 1 cycle; next request granted.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// Shared CPU bus arbitration types: state encodings, bus widths and the latched request payload.
package cpu_bus_pkg;

  localparam int unsigned BUS_AW = 32;
  localparam int unsigned BUS_DW = 32;
  localparam int unsigned TMO_W  = 16;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BUSY  = 2'd1,
    ARB_ABORT = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic              rw;
    logic [BUS_AW-1:0] address;
    logic [BUS_DW-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/cpu_bus_rr_pick.sv
// Round-robin pick: first set request searching upward from last+1, wrapping modulo PORTS.
module cpu_bus_rr_pick
  import cpu_bus_pkg::*;
#(
  parameter int unsigned PORTS = 4,
  parameter int unsigned IW    = 2
) (
  input  logic [PORTS-1:0] i_req,
  input  logic [IW-1:0]    i_last,
  output logic [IW-1:0]    o_winner_c,
  output logic             o_valid_c
);

  // Scan the rotated request vector; the port just served is checked last.
  always_comb begin
    int unsigned k;
    k          = 0;
    o_valid_c  = 1'b0;
    o_winner_c = '0;
    for (int unsigned i = 1; i <= PORTS; i++) begin
      k = (32'(i_last) + i) % PORTS;
      if (!o_valid_c && i_req[IW'(k)]) begin
        o_valid_c  = 1'b1;
        o_winner_c = IW'(k);
      end
    end
  end

endmodule

// File: rtl/cpu_bus_rr_arbiter.sv
// Round-robin arbiter sharing one CPU bus master port among PORTS requesters.
// Optional watchdog enabled by defining CPU_BUS_ARB_TIMEOUT_EN.
module cpu_bus_rr_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int unsigned PORTS   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic [PORTS-1:0]          i_req,
  input  logic [PORTS-1:0]          i_rw,
  input  logic [BUS_AW*PORTS-1:0]   i_address,
  input  logic [BUS_DW*PORTS-1:0]   i_wdata,
  output logic [PORTS-1:0]          o_ready,
  output logic [BUS_DW*PORTS-1:0]   o_rdata,
  output logic [PORTS-1:0]          o_grant,
  output logic                      o_bus_request,
  output logic                      o_bus_rw,
  output logic [BUS_AW-1:0]         o_bus_address,
  output logic [BUS_DW-1:0]         o_bus_wdata,
  input  logic                      i_bus_ready,
  input  logic [BUS_DW-1:0]         i_bus_rdata,
  output logic [PORTS-1:0]          o_error
);

  localparam int unsigned IW = (PORTS > 1) ? $clog2(PORTS) : 1;

  arb_state_e       state_q, state_d;
  logic [IW-1:0]    last_q, last_d;
  logic [PORTS-1:0] grant_q, grant_d;
  bus_req_t         bus_q, bus_d;
  bus_req_t         sel_c;
  logic [IW-1:0]    win_idx_c;
  logic             win_valid_c;

`ifdef CPU_BUS_ARB_TIMEOUT_EN
  logic [TMO_W-1:0] cnt_q, cnt_d, cnt_inc_c;
  assign cnt_inc_c = cnt_q + TMO_W'(1);
`else
  logic unused_timeout_c;
  assign unused_timeout_c = ^TMO_W'(TIMEOUT);
`endif

  cpu_bus_rr_pick #(
    .PORTS (PORTS),
    .IW    (IW)
  ) u_pick (
    .i_req      (i_req),
    .i_last     (last_q),
    .o_winner_c (win_idx_c),
    .o_valid_c  (win_valid_c)
  );

  // Payload of the current round-robin winner.
  always_comb begin
    sel_c = '0;
    for (int k = 0; k < int'(PORTS); k++) begin
      if (win_idx_c == IW'(k)) begin
        sel_c.rw      = i_rw[k];
        sel_c.address = i_address[k*BUS_AW +: BUS_AW];
        sel_c.wdata   = i_wdata[k*BUS_DW +: BUS_DW];
      end
    end
  end

  // Next-state, grant and bus payload selection.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    bus_d   = bus_q;
`ifdef CPU_BUS_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (win_valid_c) begin
          state_d = ARB_BUSY;
          last_d  = win_idx_c;
          grant_d = PORTS'(1) << win_idx_c;
          bus_d   = sel_c;
`ifdef CPU_BUS_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ARB_BUSY: begin
        if (i_bus_ready) begin
          state_d = ARB_IDLE;
          grant_d = '0;
        end
`ifdef CPU_BUS_ARB_TIMEOUT_EN
        else begin
          cnt_d = cnt_inc_c;
          if (cnt_inc_c == TMO_W'(TIMEOUT)) begin
            state_d = ARB_ABORT;
          end
        end
`endif
      end
      ARB_ABORT: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State and payload registers with synchronous reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ARB_IDLE;
      last_q  <= IW'(PORTS - 1);
      grant_q <= '0;
      bus_q   <= '0;
`ifdef CPU_BUS_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      bus_q   <= bus_d;
`ifdef CPU_BUS_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign o_grant       = grant_q;
  assign o_bus_request = (state_q == ARB_BUSY);
  assign o_bus_rw      = bus_q.rw;
  assign o_bus_address = bus_q.address;
  assign o_bus_wdata   = bus_q.wdata;
  assign o_ready       = (state_q == ARB_BUSY && i_bus_ready) ? (grant_q & i_req) : '0;

  // Read data steered only to the owning, still-requesting reader.
  for (genvar g = 0; g < int'(PORTS); g++) begin : g_rdata
    assign o_rdata[g*BUS_DW +: BUS_DW] =
      (state_q == ARB_BUSY && grant_q[g] && i_req[g] && !bus_q.rw) ? i_bus_rdata : '0;
  end

`ifdef CPU_BUS_ARB_TIMEOUT_EN
  assign o_error = (state_q == ARB_ABORT) ? grant_q : '0;
`else
  assign o_error = '0;
`endif

endmodule

// File: tb/tb_cpu_bus_rr_arbiter.sv
// Directed bench for cpu_bus_rr_arbiter; watchdog case runs when CPU_BUS_ARB_TIMEOUT_EN is defined.
module tb_cpu_bus_rr_arbiter;

  logic         i_clock = 1'b0;
  logic         i_reset;
  logic [3:0]   i_req;
  logic [3:0]   i_rw;
  logic [127:0] i_address;
  logic [127:0] i_wdata;
  logic [3:0]   o_ready;
  logic [127:0] o_rdata;
  logic [3:0]   o_grant;
  logic         o_bus_request;
  logic         o_bus_rw;
  logic [31:0]  o_bus_address;
  logic [31:0]  o_bus_wdata;
  logic         i_bus_ready;
  logic [31:0]  i_bus_rdata;
  logic [3:0]   o_error;

  int n_vec = 0;
  int n_err = 0;

  cpu_bus_rr_arbiter #(.PORTS(4), .TIMEOUT(8)) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_req         (i_req),
    .i_rw          (i_rw),
    .i_address     (i_address),
    .i_wdata       (i_wdata),
    .o_ready       (o_ready),
    .o_rdata       (o_rdata),
    .o_grant       (o_grant),
    .o_bus_request (o_bus_request),
    .o_bus_rw      (o_bus_rw),
    .o_bus_address (o_bus_address),
    .o_bus_wdata   (o_bus_wdata),
    .i_bus_ready   (i_bus_ready),
    .i_bus_rdata   (i_bus_rdata),
    .o_error       (o_error)
  );

  always #5 i_clock = ~i_clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge i_clock);
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    tick();
    tick();
    i_reset = 1'b0;
  endtask

  function automatic logic [31:0] rd(input int k);
    return o_rdata[k*32 +: 32];
  endfunction

  logic [3:0] exp_grant [9];

  initial begin
    i_reset     = 1'b0;
    i_req       = '0;
    i_rw        = '0;
    i_address   = '0;
    i_wdata     = '0;
    i_bus_ready = 1'b0;
    i_bus_rdata = '0;
    tick();
    do_reset();

    // reset state
    chk("rst_grant", 32'(o_grant), 32'h0);
    chk("rst_busreq", 32'(o_bus_request), 32'h0);
    chk("rst_addr", o_bus_address, 32'h0);
    chk("rst_ready", 32'(o_ready), 32'h0);
    chk("rst_rdata", 32'(|o_rdata), 32'h0);
    chk("rst_error", 32'(o_error), 32'h0);

    // bus ready while idle is ignored
    i_bus_ready = 1'b1;
    tick();
    chk("idle_rdy_busreq", 32'(o_bus_request), 32'h0);
    chk("idle_rdy_ready", 32'(o_ready), 32'h0);
    i_bus_ready = 1'b0;

    // 1: single read from port 1
    i_req = 4'b0010;
    i_address[32 +: 32] = 32'h0000_1000;
    tick();
    chk("t1_busreq", 32'(o_bus_request), 32'h1);
    chk("t1_grant", 32'(o_grant), 32'h2);
    chk("t1_addr", o_bus_address, 32'h0000_1000);
    chk("t1_rw", 32'(o_bus_rw), 32'h0);
    tick();
    tick();
    chk("t1_addr_hold", o_bus_address, 32'h0000_1000);
    chk("t1_ready_early", 32'(o_ready), 32'h0);
    i_bus_ready = 1'b1;
    i_bus_rdata = 32'hDEAD_BEEF;
    #1;
    chk("t1_ready", 32'(o_ready), 32'h2);
    chk("t1_rdata1", rd(1), 32'hDEAD_BEEF);
    chk("t1_rdata0", rd(0), 32'h0);
    tick();
    i_bus_ready = 1'b0;
    i_req = '0;
    #1;
    chk("t1_ready_done", 32'(o_ready), 32'h0);
    chk("t1_grant_done", 32'(o_grant), 32'h0);
    chk("t1_busreq_done", 32'(o_bus_request), 32'h0);

    // 2: all ports request, bus always ready -> 0,1,2,3,0 with idle gaps
    do_reset();
    exp_grant = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
    i_req = 4'hF;
    i_bus_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("t2_grant%0d", i), 32'(o_grant), 32'(exp_grant[i]));
      chk($sformatf("t2_ready%0d", i), 32'(o_ready), 32'(exp_grant[i]));
    end
    tick();
    i_req = '0;
    i_bus_ready = 1'b0;
    tick();

    // 3: port 2 write, port 0 arrives mid-transaction and wins next
    i_req = 4'b0100;
    i_rw[2] = 1'b1;
    i_address[64 +: 32] = 32'h0000_2000;
    i_wdata[64 +: 32] = 32'h0000_55AA;
    tick();
    chk("t3_grant", 32'(o_grant), 32'h4);
    chk("t3_wdata", o_bus_wdata, 32'h0000_55AA);
    chk("t3_rw", 32'(o_bus_rw), 32'h1);
    i_req = 4'b0101;
    i_address[0 +: 32] = 32'h0000_3000;
    i_wdata[0 +: 32] = 32'h0000_1111;
    i_bus_rdata = 32'hCAFE_F00D;
    tick();
    chk("t3_wdata_hold", o_bus_wdata, 32'h0000_55AA);
    chk("t3_addr_hold", o_bus_address, 32'h0000_2000);
    chk("t3_grant_hold", 32'(o_grant), 32'h4);
    i_bus_ready = 1'b1;
    #1;
    chk("t3_ready", 32'(o_ready), 32'h4);
    chk("t3_wr_rdata2", rd(2), 32'h0);
    tick();
    i_req = 4'b0001;
    i_bus_ready = 1'b0;
    #1;
    chk("t3_idle_grant", 32'(o_grant), 32'h0);
    tick();
    chk("t3_next_grant", 32'(o_grant), 32'h1);
    chk("t3_next_addr", o_bus_address, 32'h0000_3000);
    i_bus_ready = 1'b1;
    #1;
    chk("t3_rdata0", rd(0), 32'hCAFE_F00D);
    chk("t3_ready0", 32'(o_ready), 32'h1);
    tick();
    i_req = '0;
    i_bus_ready = 1'b0;
    tick();

    // 4: port 3 drops its request before ready
    i_req = 4'b1000;
    i_address[96 +: 32] = 32'h0000_4000;
    tick();
    chk("t4_grant", 32'(o_grant), 32'h8);
    i_req = '0;
    tick();
    chk("t4_busreq_hold", 32'(o_bus_request), 32'h1);
    chk("t4_grant_hold", 32'(o_grant), 32'h8);
    i_bus_ready = 1'b1;
    #1;
    chk("t4_no_ready", 32'(o_ready), 32'h0);
    chk("t4_no_rdata", rd(3), 32'h0);
    tick();
    i_bus_ready = 1'b0;
    chk("t4_idle_busreq", 32'(o_bus_request), 32'h0);
    chk("t4_idle_grant", 32'(o_grant), 32'h0);

    // 5: reset while busy
    i_req = 4'b0010;
    i_rw[1] = 1'b1;
    i_wdata[32 +: 32] = 32'h0000_7777;
    tick();
    chk("t5_busreq", 32'(o_bus_request), 32'h1);
    chk("t5_wdata", o_bus_wdata, 32'h0000_7777);
    i_reset = 1'b1;
    tick();
    chk("t5_busreq_rst", 32'(o_bus_request), 32'h0);
    chk("t5_grant_rst", 32'(o_grant), 32'h0);
    chk("t5_addr_rst", o_bus_address, 32'h0);
    chk("t5_wdata_rst", o_bus_wdata, 32'h0);
    chk("t5_rw_rst", 32'(o_bus_rw), 32'h0);
    i_reset = 1'b0;
    i_req = '0;
    tick();

`ifdef CPU_BUS_ARB_TIMEOUT_EN
    // 6: bus never ready -> abort after 8 busy cycles
    do_reset();
    i_req = 4'b0010;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t6_busreq%0d", i), 32'(o_bus_request), 32'h1);
      chk($sformatf("t6_err%0d", i), 32'(o_error), 32'h0);
      tick();
    end
    chk("t6_abort_busreq", 32'(o_bus_request), 32'h0);
    chk("t6_abort_error", 32'(o_error), 32'h2);
    chk("t6_abort_ready", 32'(o_ready), 32'h0);
    i_req = 4'b0100;
    tick();
    chk("t6_idle_error", 32'(o_error), 32'h0);
    chk("t6_idle_grant", 32'(o_grant), 32'h0);
    tick();
    chk("t6_next_grant", 32'(o_grant), 32'h4);
    i_req = '0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
